// File: rtl/digit_entry_pkg.sv
// Shared constants and FSM encoding for the digit-entry front end.
package digit_entry_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_DONE} state_e;

   localparam int          NUM_DIGITS = 4;
   localparam logic [3:0]  DIGIT_MAX  = 4'd9;
   localparam int          NUM_BTNS   = 5;
   localparam int          BTN_UP     = 0;
   localparam int          BTN_DOWN   = 1;
   localparam int          BTN_LEFT   = 2;
   localparam int          BTN_RIGHT  = 3;
   localparam int          BTN_ENTER  = 4;
endpackage

// File: rtl/digit_entry_btn_debounce.sv
// Two-flop synchroniser, hold-time debouncer and press (rising-edge) pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic slow_clk,
   input  logic reset,
   input  logic raw,
   output logic press
);
   logic       sync1_q, sync1_d, sync2_q, sync2_d;
   logic       db_q, db_d, db_prev_q, db_prev_d;
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d   = raw;
      sync2_d   = sync1_q;
      db_prev_d = db_q;
      db_d      = db_q;
      cnt_d     = '0;
      // The count of disagreeing cycles reaching DEBOUNCE_CYCLES flips the level.
      if (sync2_q != db_q) begin
         if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) db_d = sync2_q;
         else                                  cnt_d = cnt_q + 8'd1;
      end
      press = db_q & ~db_prev_q;
   end

   always_ff @(posedge slow_clk) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         db_q      <= db_d;
         db_prev_q <= db_prev_d;
         cnt_q     <= cnt_d;
      end
   end
endmodule

// File: rtl/digit_entry.sv
// Button-driven four-digit BCD editor with multi-cycle BCD-to-binary conversion.
module digit_entry
   import digit_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic        slow_clk,
   input  logic        reset,
   input  logic        btn_up_raw,
   input  logic        btn_down_raw,
   input  logic        btn_left_raw,
   input  logic        btn_right_raw,
   input  logic        btn_enter_raw,
   output logic [15:0] digits,
   output logic [1:0]  cursor,
   output logic [15:0] value,
   output logic        value_valid,
   output logic        busy
);
   logic [NUM_BTNS-1:0] btn_raw, press;

   assign btn_raw = {btn_enter_raw, btn_right_raw, btn_left_raw, btn_down_raw, btn_up_raw};

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .slow_clk (slow_clk),
         .reset    (reset),
         .raw      (btn_raw[i]),
         .press    (press[i])
      );
   end

   // Index 0 is the thousands digit, matching the cursor numbering.
   logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d, snap_q, snap_d;
   logic [1:0]  cur_q, cur_d, idx_q, idx_d;
   logic [15:0] acc_q, acc_d, value_q, value_d;
   state_e      state_q, state_d;

   logic up, down, left, right;
   assign up    = press[BTN_UP];
   assign down  = press[BTN_DOWN];
   assign left  = press[BTN_LEFT];
   assign right = press[BTN_RIGHT];

   always_comb begin
      state_d = state_q;
      dig_d   = dig_q;
      cur_d   = cur_q;
      snap_d  = snap_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      value_d = value_q;
      case (state_q)
         ST_IDLE: begin
            if (press[BTN_ENTER]) begin
               snap_d  = dig_q;
               acc_d   = '0;
               idx_d   = '0;
               state_d = ST_CONV;
            end else begin
               if (up && !down)
                  dig_d[cur_q] = (dig_q[cur_q] == DIGIT_MAX) ? 4'd0 : dig_q[cur_q] + 4'd1;
               else if (down && !up)
                  dig_d[cur_q] = (dig_q[cur_q] == 4'd0) ? DIGIT_MAX : dig_q[cur_q] - 4'd1;
               if (right && !left)      cur_d = cur_q + 2'd1;
               else if (left && !right) cur_d = cur_q - 2'd1;
            end
         end
         ST_CONV: begin
            acc_d = (acc_q << 3) + (acc_q << 1) + {12'd0, snap_q[idx_q]};
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               value_d = acc_d;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge slow_clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         dig_q   <= '0;
         cur_q   <= '0;
         snap_q  <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         value_q <= '0;
      end else begin
         state_q <= state_d;
         dig_q   <= dig_d;
         cur_q   <= cur_d;
         snap_q  <= snap_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         value_q <= value_d;
      end
   end

   assign digits      = {dig_q[0], dig_q[1], dig_q[2], dig_q[3]};
   assign cursor      = cur_q;
   assign value       = value_q;
   assign value_valid = (state_q == ST_DONE);
   assign busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_digit_entry.sv
// Randomized press-level bench for digit_entry with an arithmetic reference model.
module tb_digit_entry;
   import digit_entry_pkg::*;

   localparam int DC = 4;

   logic        slow_clk = 1'b0;
   logic        reset;
   logic [4:0]  btn;
   logic [15:0] digits, value;
   logic [1:0]  cursor;
   logic        value_valid, busy;

   int tests = 0, fails = 0;
   int vv_cnt = 0, busy_cnt = 0;
   int md[4];
   int mcur, mval;

   digit_entry #(.DEBOUNCE_CYCLES(DC)) dut (
      .slow_clk      (slow_clk),
      .reset         (reset),
      .btn_up_raw    (btn[BTN_UP]),
      .btn_down_raw  (btn[BTN_DOWN]),
      .btn_left_raw  (btn[BTN_LEFT]),
      .btn_right_raw (btn[BTN_RIGHT]),
      .btn_enter_raw (btn[BTN_ENTER]),
      .digits        (digits),
      .cursor        (cursor),
      .value         (value),
      .value_valid   (value_valid),
      .busy          (busy)
   );

   always #5 slow_clk = ~slow_clk;

   always @(negedge slow_clk) begin
      if (value_valid) vv_cnt++;
      if (busy)        busy_cnt++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      if (obs != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic int exp_digits();
      return md[0] * 4096 + md[1] * 256 + md[2] * 16 + md[3];
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) md[i] = 0;
      mcur = 0;
      mval = 0;
   endfunction

   // Apply one simultaneous press of the buttons in mask to the model.
   function automatic void model_press(input logic [4:0] mask);
      if (mask[BTN_ENTER]) begin
         mval = md[0] * 1000 + md[1] * 100 + md[2] * 10 + md[3];
         return;
      end
      if (mask[BTN_UP] && !mask[BTN_DOWN])      md[mcur] = (md[mcur] + 1) % 10;
      else if (mask[BTN_DOWN] && !mask[BTN_UP]) md[mcur] = (md[mcur] + 9) % 10;
      if (mask[BTN_RIGHT] && !mask[BTN_LEFT])      mcur = (mcur + 1) % 4;
      else if (mask[BTN_LEFT] && !mask[BTN_RIGHT]) mcur = (mcur + 3) % 4;
   endfunction

   task automatic press(input logic [4:0] mask, input int hold, input int rel);
      int vv0, b0;
      logic conv;
      vv0  = vv_cnt;
      b0   = busy_cnt;
      conv = (hold >= DC) && mask[BTN_ENTER];
      btn = mask;
      repeat (hold) @(negedge slow_clk);
      btn = '0;
      repeat (rel) @(negedge slow_clk);
      if (hold >= DC) model_press(mask);
      check("digits", int'(digits), exp_digits());
      check("cursor", int'(cursor), mcur);
      check("value", int'(value), mval);
      check("vv_pulses", vv_cnt - vv0, conv ? 1 : 0);
      check("busy_cycles", busy_cnt - b0, conv ? 5 : 0);
   endtask

   task automatic tap(input int b);
      logic [4:0] m;
      m = '0;
      m[b] = 1'b1;
      press(m, 6, 9);
   endtask

   initial begin
      btn   = '0;
      reset = 1'b1;
      model_reset();
      repeat (3) @(negedge slow_clk);
      check("rst_digits", int'(digits), 0);
      check("rst_cursor", int'(cursor), 0);
      check("rst_value", int'(value), 0);
      check("rst_vv", int'(value_valid), 0);
      check("rst_busy", int'(busy), 0);
      reset = 1'b0;

      // Press latency: digit changes on the edge 2+DC after the first sample.
      btn[BTN_UP] = 1'b1;
      repeat (6) @(negedge slow_clk);
      check("lat_early", int'(digits), 0);
      @(negedge slow_clk);
      check("lat_hit", int'(digits), 16'h1000);
      repeat (3) @(negedge slow_clk);
      check("lat_held", int'(digits), 16'h1000);
      btn = '0;
      repeat (10) @(negedge slow_clk);
      check("lat_released", int'(digits), 16'h1000);
      md[0] = 1;

      // 1,2,3,4 then enter.
      tap(BTN_RIGHT); tap(BTN_UP); tap(BTN_UP);
      tap(BTN_RIGHT); repeat (3) tap(BTN_UP);
      tap(BTN_RIGHT); repeat (4) tap(BTN_UP);
      check("d1234", int'(digits), 16'h1234);
      tap(BTN_ENTER);
      check("v1234", int'(value), 1234);

      // Wraps on the ones digit and cursor.
      repeat (5) tap(BTN_DOWN);
      tap(BTN_UP);
      tap(BTN_DOWN);
      press(5'b00011, 6, 9);
      tap(BTN_RIGHT);
      tap(BTN_LEFT);
      check("wrap_cursor", int'(cursor), 3);

      // 9999, then up pressed while the conversion is running.
      for (int d = 0; d < 4; d++) begin
         while (md[mcur] != 9) tap(BTN_UP);
         tap(BTN_RIGHT);
      end
      begin
         int vv0;
         vv0 = vv_cnt;
         btn[BTN_ENTER] = 1'b1;
         @(negedge slow_clk);
         btn[BTN_UP] = 1'b1;
         repeat (10) @(negedge slow_clk);
         btn = '0;
         repeat (12) @(negedge slow_clk);
         check("v9999", int'(value), 9999);
         check("v9999_vv", vv_cnt - vv0, 1);
         check("busy_drop", int'(digits), 16'h9999);
         mval = 9999;
      end

      // Short glitch on enter.
      press(5'b10000, 2, 10);

      // Randomized presses and glitches.
      for (int n = 0; n < 60; n++) begin
         logic [4:0] m;
         int h;
         m = 5'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) m[BTN_ENTER] = 1'b1;
         h = ($urandom_range(0, 4) == 0) ? $urandom_range(1, DC - 1) : $urandom_range(DC + 1, 12);
         press(m, h, $urandom_range(8, 14));
      end

      // Reset in the second conversion cycle.
      begin
         int vv0, n;
         vv0 = vv_cnt;
         n   = 0;
         btn[BTN_ENTER] = 1'b1;
         while (!busy && n < 20) begin
            @(negedge slow_clk);
            n++;
         end
         check("rc_busy_seen", int'(busy), 1);
         @(negedge slow_clk);
         reset = 1'b1;
         btn   = '0;
         @(negedge slow_clk);
         model_reset();
         check("rc_value", int'(value), 0);
         check("rc_digits", int'(digits), 0);
         check("rc_cursor", int'(cursor), 0);
         check("rc_busy", int'(busy), 0);
         reset = 1'b0;
         repeat (10) @(negedge slow_clk);
         check("rc_no_vv", vv_cnt - vv0, 0);
         check("rc_value_after", int'(value), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
